// File: rtl/lcd_arb_pkg.sv
// Shared Op encodings and FSM state type for the LCD command arbiter.
package lcd_arb_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_ROW   = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RELEASE,
        ST_ACK
    } state_t;

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr (wrapping) wins.
// Returns the winner both one-hot and as an index; all-zero when nobody requests.
module lcd_rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    int   idx;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/lcd_arbiter.sv
// Round-robin arbiter sharing one LCD controller among N_REQ requesters; Ack >= 3 cycles after grant plus LCD busy time.
// Grants only while Done is high; optional watchdog under LCD_ARB_TIMEOUT_EN.
module lcd_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int CHARS   = 20,
    parameter int TMO_CYC = 1000000
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic [N_REQ-1:0]         Req,
    input  logic [2*N_REQ-1:0]       Op,
    input  logic [8*CHARS*N_REQ-1:0] Dato,
    output logic [N_REQ-1:0]         Ack,
    output logic [N_REQ-1:0]         Grant,
    output logic                     Limpiar,
    output logic                     Escribir,
    output logic                     Cambio_Fila,
    output logic [8*CHARS-1:0]       Dato_LCD,
    input  logic                     Done,
    output logic                     Error
);

    localparam int DW = 8 * CHARS;
    localparam int PW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TMO_CYC < 1) begin : g_bad_cfg
        $error("lcd_arbiter: parameter out of range");
    end

    state_t          state, state_nx;
    logic [PW-1:0]   ptr, win_idx;
    logic [1:0]      op_q;
    logic [N_REQ-1:0] arb_gnt;
    logic [PW-1:0]   arb_idx;
    logic [1:0]      op_sel;
    logic [DW-1:0]   dato_sel;
    logic            take;
    logic            err_set;

    lcd_rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
        .req     (Req),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign op_sel   = Op[2*arb_idx +: 2];
    assign dato_sel = Dato[DW*arb_idx +: DW];

`ifdef LCD_ARB_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        busy;
    logic        tmo_hit;

    assign busy    = (state == ST_ISSUE) || (state == ST_RELEASE);
    assign tmo_hit = busy && (tmo_cnt == 32'(TMO_CYC - 1));

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)    tmo_cnt <= '0;
        else if (busy) tmo_cnt <= tmo_cnt + 32'd1;
        else           tmo_cnt <= '0;
    end
`endif

    always_comb begin
        state_nx    = state;
        take        = 1'b0;
        err_set     = 1'b0;
        Ack         = '0;
        Escribir    = 1'b0;
        Limpiar     = 1'b0;
        Cambio_Fila = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((|Req) && Done) begin
                    take = 1'b1;
                    // Reserved op never reaches the LCD: straight to the Ack cycle.
                    if (op_sel == OP_RSVD) begin
                        err_set  = 1'b1;
                        state_nx = ST_ACK;
                    end else begin
                        state_nx = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                case (op_q)
                    OP_WRITE: Escribir    = 1'b1;
                    OP_CLEAR: Limpiar     = 1'b1;
                    OP_ROW:   Cambio_Fila = 1'b1;
                    default:  ;
                endcase
                if (!Done) state_nx = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (Done) state_nx = ST_ACK;
            end
            ST_ACK: begin
                Ack      = Grant;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
`ifdef LCD_ARB_TIMEOUT_EN
        if (tmo_hit) begin
            Escribir    = 1'b0;
            Limpiar     = 1'b0;
            Cambio_Fila = 1'b0;
            err_set     = 1'b1;
            state_nx    = ST_ACK;
        end
`endif
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            ptr      <= PW'(N_REQ - 1);
            win_idx  <= '0;
            op_q     <= OP_WRITE;
            Grant    <= '0;
            Dato_LCD <= '0;
            Error    <= 1'b0;
        end else begin
            state <= state_nx;
            if (err_set) Error <= 1'b1;
            if (take) begin
                Grant    <= arb_gnt;
                win_idx  <= arb_idx;
                op_q     <= op_sel;
                Dato_LCD <= dato_sel;
            end
            if (state == ST_ACK) begin
                Grant <= '0;
                ptr   <= win_idx;
            end
        end
    end

endmodule

// File: tb/tb_lcd_arbiter.sv
// Directed bench for lcd_arbiter (default build, N_REQ=3, CHARS=20); all driving and sampling on the falling edge.
module tb_lcd_arbiter;

    localparam int N  = 3;
    localparam int DW = 160;

    logic            CLK;
    logic            Reset;
    logic [N-1:0]    Req;
    logic [2*N-1:0]  Op;
    logic [DW*N-1:0] Dato;
    logic [N-1:0]    Ack, Grant;
    logic            Limpiar, Escribir, Cambio_Fila;
    logic [DW-1:0]   Dato_LCD;
    logic            Done;
    logic            Error;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] hola;
    logic          ack_seen;

    lcd_arbiter #(.N_REQ(N), .CHARS(20), .TMO_CYC(1000000)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Req         (Req),
        .Op          (Op),
        .Dato        (Dato),
        .Ack         (Ack),
        .Grant       (Grant),
        .Limpiar     (Limpiar),
        .Escribir    (Escribir),
        .Cambio_Fila (Cambio_Fila),
        .Dato_LCD    (Dato_LCD),
        .Done        (Done),
        .Error       (Error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    // Waits for a grant, plays one short LCD busy period, then waits for the Ack.
    task automatic run_op(input string tag, input logic [N-1:0] exp_gnt, input logic [2:0] exp_cmd);
        int i;
        i = 0;
        do begin @(negedge CLK); i++; end while (Grant == '0 && i < 50);
        chk({tag, "_grant"}, DW'(Grant), DW'(exp_gnt));
        chk({tag, "_cmd"}, DW'({Cambio_Fila, Limpiar, Escribir}), DW'(exp_cmd));
        Done = 1'b0;
        @(negedge CLK);
        Done = 1'b1;
        i = 0;
        do begin @(negedge CLK); i++; end while (Ack == '0 && i < 50);
        chk({tag, "_ack"}, DW'(Ack), DW'(exp_gnt));
    endtask

    initial begin
        hola  = "HOLA MUNDO LCD TEST!";
        Reset = 1'b0;
        Req   = '0;
        Op    = '0;
        Dato  = '0;
        Done  = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_grant", DW'(Grant), '0);
        chk("rst_ack", DW'(Ack), '0);
        chk("rst_cmd", DW'({Cambio_Fila, Limpiar, Escribir}), '0);
        chk("rst_dato", Dato_LCD, '0);
        chk("rst_err", DW'(Error), '0);
        Reset = 1'b1;

        // Single write with a 50-cycle LCD busy period; inputs change after grant.
        @(negedge CLK);
        Dato[DW-1:0]  = hola;
        Dato[2*DW-1:DW] = {DW{1'b1}};
        Req = 3'b001;
        @(negedge CLK);
        chk("w_grant", DW'(Grant), DW'(3'b001));
        chk("w_escr", DW'({Cambio_Fila, Limpiar, Escribir}), DW'(3'b001));
        chk("w_dato", Dato_LCD, hola);
        Req = 3'b000;
        Dato[DW-1:0] = {DW{1'b0}};
        @(negedge CLK);
        chk("w_escr_hold", DW'(Escribir), DW'(1'b1));
        Done = 1'b0;
        @(negedge CLK);
        chk("w_escr_drop", DW'(Escribir), '0);
        ack_seen = 1'b0;
        for (int i = 0; i < 49; i++) begin
            @(negedge CLK);
            if (Ack != '0) ack_seen = 1'b1;
        end
        chk("w_no_early_ack", DW'(ack_seen), '0);
        Done = 1'b1;
        @(negedge CLK);
        chk("w_ack", DW'(Ack), DW'(3'b001));
        @(negedge CLK);
        chk("w_ack_once", DW'(Ack), '0);
        chk("w_grant_clr", DW'(Grant), '0);
        chk("w_dato_keep", Dato_LCD, hola);

        // Fresh reset puts the pointer back at N-1; all three requesting.
        Reset = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        Op  = 6'b00_00_00;
        Req = 3'b111;
        run_op("rr0", 3'b001, 3'b001);
        run_op("rr1", 3'b010, 3'b001);
        run_op("rr2", 3'b100, 3'b001);
        run_op("rr3", 3'b001, 3'b001);
        Req = 3'b000;

        // No grant while the LCD reports busy.
        @(negedge CLK);
        Done = 1'b0;
        Req  = 3'b001;
        repeat (5) @(negedge CLK);
        chk("busy_no_grant", DW'(Grant), '0);
        Done = 1'b1;
        run_op("busy_then", 3'b001, 3'b001);
        Req = 3'b000;

        // Clear and next-row commands.
        Op  = 6'b10_01_00;
        @(negedge CLK);
        Req = 3'b010;
        run_op("clr", 3'b010, 3'b010);
        Req = 3'b000;
        @(negedge CLK);
        Req = 3'b100;
        run_op("row", 3'b100, 3'b100);
        Req = 3'b000;
        chk("err_before_rsvd", DW'(Error), '0);

        // Reserved op: immediate Ack, no command, sticky error.
        @(negedge CLK);
        Op  = 6'b10_01_11;
        Req = 3'b001;
        @(negedge CLK);
        chk("rsvd_ack", DW'(Ack), DW'(3'b001));
        chk("rsvd_cmd", DW'({Cambio_Fila, Limpiar, Escribir}), '0);
        chk("rsvd_err", DW'(Error), DW'(1'b1));
        Req = 3'b000;
        @(negedge CLK);
        chk("rsvd_ack_once", DW'(Ack), '0);
        chk("rsvd_err_sticky", DW'(Error), DW'(1'b1));

        // Reset while waiting in RELEASE aborts without Ack.
        Op = 6'b10_01_00;
        Dato[DW-1:0] = hola;
        Req = 3'b001;
        begin
            int i;
            i = 0;
            do begin @(negedge CLK); i++; end while (Grant == '0 && i < 50);
        end
        Done = 1'b0;
        @(negedge CLK);
        chk("rr_in_release", DW'({Cambio_Fila, Limpiar, Escribir}), '0);
        Reset = 1'b0;
        #1;
        chk("mid_rst_grant", DW'(Grant), '0);
        chk("mid_rst_dato", Dato_LCD, '0);
        chk("mid_rst_err", DW'(Error), '0);
        ack_seen = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            if (Ack != '0) ack_seen = 1'b1;
        end
        chk("mid_rst_no_ack", DW'(ack_seen), '0);
        Done  = 1'b1;
        Reset = 1'b1;
        run_op("post_rst", 3'b001, 3'b001);
        Req = 3'b000;
        @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_arbiter.md
LCD_ARBITER -- requirements
Module: lcd_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of requesters (2..8).
REQ-002 SHALL have parameter CHARS, default 20, characters per line; DW = 8*CHARS.
REQ-003 SHALL have parameter TMO_CYC, default 1000000, watchdog limit in cycles.
REQ-004 SHALL have port CLK  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port Req  in  N_REQ  per-requester request level.
REQ-007 SHALL have port Op  in  2*N_REQ  per-requester command: 00 write, 01 clear, 10 next row, 11 reserved.
REQ-008 SHALL have port Dato  in  DW*N_REQ  per-requester line data, requester i at [DW*i +: DW].
REQ-009 SHALL have port Ack  out  N_REQ  one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port Grant  out  N_REQ  one-hot owner, zero when idle.
REQ-011 SHALL have ports Limpiar, Escribir, Cambio_Fila  out  1 each  command levels to the LCD controller.
REQ-012 SHALL have port Dato_LCD  out  DW  latched data to the LCD controller.
REQ-013 SHALL have port Done  in  1  LCD controller ready/idle flag.
REQ-014 SHALL have port Error  out  1  sticky fault flag.

Function
REQ-015 SHALL implement FSM IDLE, ISSUE, RELEASE, ACK.
REQ-016 IDLE: if any Req high and Done high, SHALL pick winner round-robin starting at pointer+1, latch its Op and Dato, set Grant, and go to ISSUE next cycle.
REQ-017 ISSUE SHALL hold exactly one of Escribir/Limpiar/Cambio_Fila per latched Op until Done is sampled low, then go to RELEASE.
REQ-018 RELEASE SHALL drive all three commands low and wait for Done high, then go to ACK.
REQ-019 ACK SHALL pulse Ack for the winner for one cycle, advance pointer to the winner, clear Grant, and return to IDLE.
REQ-020 Latency from grant to Ack SHALL be at least 3 cycles plus LCD busy time.
REQ-021 Op 11 SHALL be ignored: the requester is skipped, no command is issued, Ack is pulsed in one cycle, and Error is set.
REQ-022 Req and Dato changes after the grant SHALL NOT affect the operation in progress.
REQ-023 A requester holding Req after Ack SHALL rejoin arbitration and SHALL NOT win again while others are pending.
REQ-024 Simultaneous requests SHALL resolve in strict round-robin order, with no starvation within N_REQ grants.
REQ-025 With Done low in IDLE, SHALL NOT grant anyone.
REQ-026 Dato_LCD SHALL change only at grant.

Reset
REQ-027 Reset low SHALL force IDLE immediately, pointer = N_REQ-1, and all outputs to 0 (Grant, Ack, commands, Dato_LCD, Error).
REQ-028 Reset mid-operation SHALL abort without Ack; requesters re-request.

Configuration
REQ-029 With LCD_ARB_TIMEOUT_EN defined, a counter SHALL run in ISSUE/RELEASE; on reaching TMO_CYC it SHALL drop commands, set Error, pulse Ack, and return to IDLE.
REQ-030 Without LCD_ARB_TIMEOUT_EN, no counter SHALL exist and ISSUE/RELEASE SHALL wait indefinitely.

Structure
REQ-031 Package lcd_arb_pkg SHALL hold the Op encodings and FSM state constants.
REQ-032 Round-robin selection SHALL be the sub-module lcd_rr_arbiter (Req, pointer -> one-hot winner).

Verification
REQ-033 Single Req[0], Op=00, Dato="HOLA...", Done drops 2 cycles after Escribir and returns 50 cycles later -> Escribir high until Done low, Dato_LCD latched, Ack[0] one pulse after Done high.
REQ-034 Req=111 held continuously, pointer=2 -> grants in order 0,1,2,0.
REQ-035 Req[1] Op=01 -> only Limpiar asserted; Req[2] Op=10 -> only Cambio_Fila asserted.
REQ-036 Op=11 on Req[0] -> no command issued, Ack[0] pulsed, Error=1.
REQ-037 With LCD_ARB_TIMEOUT_EN and TMO_CYC=16, Done stuck high -> abort at cycle 16, Error=1, Ack pulsed.
REQ-038 Reset low during RELEASE -> all outputs 0 next edge, no Ack, new grant after reset release.
